// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC transmit arbiter.
// Holds the FSM state enum and the round-robin pick function.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int MAX_REQ = 8;
  localparam int NOC_ADDR_IDLE = 0;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First valid index after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int                 n
  );
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      k = (int'(ptr) + i) % n;
      if (i <= n && !r.found && valid[k[2:0]]) begin
        r.found = 1'b1;
        r.idx   = k[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_tx_arbiter_if.sv
// Requester-side valid/ready bundle for the NoC transmit arbiter.
// Each requester owns one lane of the packed addr/data vectors.
interface noc_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Searches from ptr+1 upward, wrapping, for the first valid.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [MAX_REQ-1:0] v_ext;
  rr_pick_t           pick;

  // Widen to the package width and run the pick.
  always_comb begin
    v_ext = '0;
    v_ext[NUM_REQ-1:0] = valid;
    pick  = rr_pick(v_ext, 3'(ptr), NUM_REQ);
    any   = pick.found;
    idx   = IDX_W'(pick.idx);
    grant = '0;
    if (pick.found)
      grant = NUM_REQ'(1) << idx;
  end

endmodule

// File: rtl/noc_tx_arbiter.sv
// Shares the outbound NoC PIO link among several requesters.
// Each word is held HOLD_CYCLES, then address 0 for GAP_CYCLES.
module noc_tx_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  noc_tx_arbiter_if.slave    rq,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [DATA_W-1:0]  data_out,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_id,
  output logic               drop_err
);

  localparam int CNT_MAX =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    rr;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    win_idx;
  logic                any;
  logic                accept;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .valid (rq.req_valid),
    .ptr   (rr),
    .grant (grant),
    .idx   (win_idx),
    .any   (any)
  );

  // Winner lane select and the accept pulse, offered only in IDLE.
  always_comb begin
    pick_addr    = rq.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    pick_data    = rq.req_data[int'(win_idx)*DATA_W +: DATA_W];
    accept       = (state == IDLE) && any && !reset;
    rq.req_ready = accept ? grant : '0;
  end

  // Link FSM: accept in IDLE, hold word in SEND, force idle in GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rr       <= IDX_W'(NUM_REQ-1);
      grant_id <= IDX_W'(NUM_REQ-1);
      addr_out <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            rr       <= win_idx;
            grant_id <= win_idx;
            if (pick_addr == ADDR_W'(NOC_ADDR_IDLE)) begin
              drop_err <= 1'b1;
            end else begin
              addr_out <= pick_addr;
              data_out <= pick_data;
              cnt      <= CNT_W'(HOLD_CYCLES-1);
              busy     <= 1'b1;
              state    <= SEND;
            end
          end
        end
        SEND: begin
          if (cnt == '0) begin
            addr_out <= ADDR_W'(NOC_ADDR_IDLE);
            cnt      <= CNT_W'(GAP_CYCLES-1);
            state    <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Bench for noc_tx_arbiter: directed scenarios plus a randomized
// run checked against a timing model of the link protocol.
module tb_noc_tx_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int H  = 4;
  localparam int G  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  noc_tx_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) rq ();

  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic [1:0]    grant_id;
  logic          drop_err;

  noc_tx_arbiter #(
    .NUM_REQ     (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rq       (rq),
    .addr_out (addr_out),
    .data_out (data_out),
    .busy     (busy),
    .grant_id (grant_id),
    .drop_err (drop_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [N-1:0]  v;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  task automatic drive();
    logic [N*AW-1:0] pa;
    logic [N*DW-1:0] pd;
    for (int i = 0; i < N; i++) begin
      pa[i*AW +: AW] = a[i];
      pd[i*DW +: DW] = d[i];
    end
    rq.req_valid = v;
    rq.req_addr  = pa;
    rq.req_data  = pd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic val,
                         input logic [AW-1:0] ad,
                         input logic [DW-1:0] da);
    v[i] = val;
    a[i] = ad;
    d[i] = da;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    drive();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (rq.req_ready == '0 && w < 20) begin
      tick();
      #1;
      w++;
    end
    if (rq.req_ready == '0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no ready within 20 cycles", tag);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if ({addr_out, data_out, busy, drop_err} !== '0) begin
      fails++;
      $display("FAIL reset_outs: got addr=%h data=%h busy=%b drop=%b want zeros",
               addr_out, data_out, busy, drop_err);
    end
    tests++;
    if (grant_id !== 2'd3) begin
      fails++;
      $display("FAIL reset_gid: got %0d want 3", grant_id);
    end
    tests++;
    if (rq.req_ready !== '0) begin
      fails++;
      $display("FAIL reset_ready: got %b want 0000", rq.req_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 8'h12, 32'hDEADBEEF);
    #1;
    tests++;
    if (rq.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL single_ready: got %b want 0001", rq.req_ready);
    end
    tick();
    set_req(0, 1'b0, 8'h00, 32'h0);
    for (int k = 1; k <= H + G + 1; k++) begin
      logic [AW-1:0] ea;
      logic          eb;
      #1;
      ea = (k <= H) ? 8'h12 : 8'h00;
      eb = (k <= H + G);
      tests++;
      if ({addr_out, data_out, busy} !== {ea, 32'hDEADBEEF, eb}) begin
        fails++;
        $display("FAIL single_t%0d: got addr=%h data=%h busy=%b want addr=%h data=deadbeef busy=%b",
                 k, addr_out, data_out, busy, ea, eb);
      end
      tick();
    end
  endtask

  task automatic test_all_rr();
    int exp;
    int last;
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, AW'(8'h10 + i), $urandom);
    exp = 0;
    last = 0;
    for (int g = 0; g < 8; g++) begin
      #1;
      wait_ready("rr");
      tests++;
      if (rq.req_ready !== (N'(1) << exp)) begin
        fails++;
        $display("FAIL rr_order%0d: got %b want %b",
                 g, rq.req_ready, N'(1) << exp);
      end
      if (g > 0) begin
        tests++;
        if (cyc_cnt - last != H + G + 1) begin
          fails++;
          $display("FAIL rr_period%0d: got %0d want %0d",
                   g, cyc_cnt - last, H + G + 1);
        end
      end
      last = cyc_cnt;
      tick();
      #1;
      tests++;
      if ({grant_id, addr_out} !== {2'(exp), AW'(8'h10 + exp)}) begin
        fails++;
        $display("FAIL rr_link%0d: got gid=%0d addr=%h want gid=%0d addr=%h",
                 g, grant_id, addr_out, exp, 8'h10 + exp);
      end
      exp = (exp + 1) % N;
    end
  endtask

  task automatic test_rr_ptr();
    int t0;
    do_reset();
    set_req(2, 1'b1, 8'h22, 32'h2222);
    #1;
    t0 = cyc_cnt;
    tests++;
    if (rq.req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL ptr_first: got %b want 0100", rq.req_ready);
    end
    tick();
    set_req(2, 1'b0, 8'h00, 32'h0);
    set_req(1, 1'b1, 8'h21, 32'h1111);
    set_req(3, 1'b1, 8'h23, 32'h3333);
    #1;
    wait_ready("ptr3");
    tests++;
    if (rq.req_ready !== 4'b1000 || cyc_cnt - t0 != H + G + 1) begin
      fails++;
      $display("FAIL ptr_second: got %b at +%0d want 1000 at +%0d",
               rq.req_ready, cyc_cnt - t0, H + G + 1);
    end
    tick();
    set_req(3, 1'b0, 8'h00, 32'h0);
    #1;
    wait_ready("ptr1");
    tests++;
    if (rq.req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL ptr_third: got %b want 0010", rq.req_ready);
    end
    tick();
    set_req(1, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic test_zero_addr();
    do_reset();
    set_req(1, 1'b1, 8'h00, 32'hCAFE0001);
    #1;
    tests++;
    if (rq.req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL zero_ready: got %b want 0010", rq.req_ready);
    end
    tick();
    set_req(1, 1'b0, 8'h00, 32'h0);
    set_req(0, 1'b1, 8'h33, 32'h00330033);
    #1;
    tests++;
    if ({drop_err, busy, addr_out, data_out, grant_id} !==
        {1'b1, 1'b0, 8'h00, 32'h0, 2'd1}) begin
      fails++;
      $display("FAIL zero_drop: got drop=%b busy=%b addr=%h data=%h gid=%0d want 1 0 00 0 1",
               drop_err, busy, addr_out, data_out, grant_id);
    end
    tests++;
    if (rq.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL zero_next: got %b want 0001", rq.req_ready);
    end
    tick();
    set_req(0, 1'b0, 8'h00, 32'h0);
    #1;
    tests++;
    if ({drop_err, busy, addr_out} !== {1'b0, 1'b1, 8'h33}) begin
      fails++;
      $display("FAIL zero_after: got drop=%b busy=%b addr=%h want 0 1 33",
               drop_err, busy, addr_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 8'h44, 32'h55);
    tick();
    set_req(0, 1'b1, 8'h45, 32'h56);
    set_req(2, 1'b1, 8'h46, 32'h57);
    tick();
    reset = 1'b1;
    #1;
    tests++;
    if (rq.req_ready !== '0 || addr_out !== 8'h44) begin
      fails++;
      $display("FAIL mid_send: got ready=%b addr=%h want 0000 44",
               rq.req_ready, addr_out);
    end
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if ({addr_out, data_out, busy, grant_id, drop_err} !==
        {8'h00, 32'h0, 1'b0, 2'd3, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset: got addr=%h data=%h busy=%b gid=%0d drop=%b want 00 0 0 3 0",
               addr_out, data_out, busy, grant_id, drop_err);
    end
    tests++;
    if (rq.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL mid_regrant: got %b want 0001", rq.req_ready);
    end
    tick();
    set_req(0, 1'b0, 8'h00, 32'h0);
    set_req(2, 1'b0, 8'h00, 32'h0);
    #1;
    tests++;
    if (addr_out !== 8'h45) begin
      fails++;
      $display("FAIL mid_word: got %h want 45", addr_out);
    end
  endtask

  task automatic test_gap_glitch();
    logic seen;
    do_reset();
    set_req(0, 1'b1, 8'h50, 32'h5050);
    tick();
    set_req(0, 1'b0, 8'h00, 32'h0);
    for (int k = 0; k < H; k++) tick();
    set_req(3, 1'b1, 8'h53, 32'h5353);
    #1;
    tests++;
    if ({rq.req_ready, busy, addr_out} !== {4'b0000, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL gap_state: got ready=%b busy=%b addr=%h want 0000 1 00",
               rq.req_ready, busy, addr_out);
    end
    tick();
    set_req(3, 1'b0, 8'h00, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rq.req_ready != '0) seen = 1'b1;
      tick();
    end
    #1;
    tests++;
    if ({seen, busy, addr_out, grant_id} !== {1'b0, 1'b0, 8'h00, 2'd0}) begin
      fails++;
      $display("FAIL gap_glitch: got ready_seen=%b busy=%b addr=%h gid=%0d want 0 0 00 0",
               seen, busy, addr_out, grant_id);
    end
  endtask

  task automatic test_random();
    int            m_rr;
    int            m_gid;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_waddr;
    int            t_a;
    int            drop_at;
    logic [N-1:0]  acc;
    int            wait_cnt [N];
    int            max_wait;
    do_reset();
    m_rr = N - 1;
    m_gid = N - 1;
    m_data = '0;
    m_waddr = '0;
    t_a = -100;
    drop_at = -100;
    acc = '0;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 800; c++) begin
      logic          sending;
      logic          e_busy;
      logic [AW-1:0] e_addr;
      logic [N-1:0]  e_ready;
      int            win;
      for (int i = 0; i < N; i++) begin
        if (v[i] && acc[i]) begin
          v[i] = 1'b0;
        end else if (v[i] && $urandom_range(0, 19) == 0) begin
          v[i] = 1'b0;
        end else if (!v[i] && $urandom_range(0, 9) < 3) begin
          v[i] = 1'b1;
          a[i] = ($urandom_range(0, 7) == 0) ? '0 :
                 AW'($urandom_range(1, 255));
          d[i] = $urandom;
        end
        if (!v[i]) wait_cnt[i] = 0;
      end
      drive();
      #1;
      sending = (c >= t_a + 1) && (c <= t_a + H + G);
      e_busy = sending;
      e_addr = (sending && c <= t_a + H) ? m_waddr : '0;
      e_ready = '0;
      win = -1;
      if (!sending) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (win < 0 && v[j]) win = j;
        end
      end
      if (win >= 0) e_ready[win] = 1'b1;
      tests++;
      if (rq.req_ready !== e_ready) begin
        fails++;
        $display("FAIL rnd_ready c%0d: got %b want %b", c, rq.req_ready, e_ready);
      end
      tests++;
      if (addr_out !== e_addr || busy !== e_busy) begin
        fails++;
        $display("FAIL rnd_link c%0d: got addr=%h busy=%b want addr=%h busy=%b",
                 c, addr_out, busy, e_addr, e_busy);
      end
      tests++;
      if (data_out !== m_data || grant_id !== 2'(m_gid)) begin
        fails++;
        $display("FAIL rnd_data c%0d: got data=%h gid=%0d want data=%h gid=%0d",
                 c, data_out, grant_id, m_data, m_gid);
      end
      tests++;
      if (drop_err !== (drop_at == c)) begin
        fails++;
        $display("FAIL rnd_drop c%0d: got %b want %b", c, drop_err, drop_at == c);
      end
      acc = e_ready;
      if (win >= 0) begin
        for (int i = 0; i < N; i++) begin
          if (i != win && v[i]) begin
            wait_cnt[i]++;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
          end
        end
        wait_cnt[win] = 0;
        m_rr = win;
        m_gid = win;
        if (a[win] == '0) begin
          drop_at = c + 1;
        end else begin
          t_a = c;
          m_waddr = a[win];
          m_data = d[win];
        end
      end
      tick();
    end
    tests++;
    if (max_wait > N - 1) begin
      fails++;
      $display("FAIL rnd_fair: got max wait %0d want <= %0d", max_wait, N - 1);
    end
  endtask

  initial begin
    v = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    drive();
    test_reset();
    test_single();
    test_all_rr();
    test_rr_ptr();
    test_zero_addr();
    test_reset_mid();
    test_gap_glitch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_tx_arbiter.md
Name: noc_tx_arbiter

Overview:
- Shares the single outbound NoC PIO link (8-bit address, 32-bit data) between several on-chip requesters, e.g. ReCOP datacall and debug/trace sources.
- Round-robin arbitration over a valid/ready handshake.
- Each granted word is held stable on the link for a fixed number of cycles so the polling Nios side samples it, then the link is driven idle (address 0) for a guard gap.
- Sits between the requesters and the addr_out/data_out PIO exports of the NOC system.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, link address width.
- DATA_W, 32, link data width.
- HOLD_CYCLES, 4, cycles a word is held on the link (>=1).
- GAP_CYCLES, 2, cycles address is forced to 0 after each word (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester word pending
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i occupies [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed payloads; same packing as req_addr
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot or zero
- addr_out  out  ADDR_W  to addr_out PIO; 0 = idle
- data_out  out  DATA_W  to data_out PIO
- busy  out  1  high in SEND and GAP
- grant_id  out  clog2(NUM_REQ)  index of last accepted requester
- drop_err  out  1  one-cycle pulse when an accepted word had address 0

Behaviour:
Clock, reset and handshake:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: addr_out=0, data_out=0, req_ready=0, busy=0, grant_id=NUM_REQ-1, drop_err=0, rr pointer=NUM_REQ-1 (requester 0 wins first), state IDLE, counter 0.
- Reset asserted mid-SEND or mid-GAP aborts the word; all outputs take reset values after that edge.
- Requester rule: hold valid/addr/data stable until it sees ready. A word is consumed only on a cycle where both valid and ready are high. Valid withdrawn before ready is legal; nothing is sent.

State machine (states IDLE, SEND, GAP; counter sized for max(HOLD_CYCLES, GAP_CYCLES)):
- IDLE, no valid: stay; addr_out=0; data_out keeps its last value.
- IDLE, any valid at cycle t: winner = first valid index searching rr+1, rr+2, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in cycle t.
  - On the edge ending t: register addr/data into addr_out/data_out, rr=grant_id=winner, counter=HOLD_CYCLES-1, go to SEND.
- Zero address: a winner with addr 0 is still accepted (ready pulses). No SEND occurs: drop_err pulses in cycle t+1, state stays IDLE, rr advances to the winner, outputs are unchanged.
- SEND: addr_out/data_out stable. Decrement the counter; when it is 0, go to GAP with counter=GAP_CYCLES-1 and addr_out=0 on that edge.
- GAP: addr_out=0, data_out held. Decrement; when it is 0, go to IDLE.

Timing:
- Word visible cycles t+1 .. t+HOLD_CYCLES.
- Address 0 for cycles t+HOLD+1 .. t+HOLD+GAP.
- Earliest next accept is cycle t+HOLD+GAP+1.
- req_ready is never asserted outside IDLE.
- New valids arriving in SEND/GAP wait; there is no buffering.

Fairness:
- A continuously requesting source waits at most NUM_REQ-1 transfers.

Decomposition:
- Package noc_pkg holds:
  - state enum {IDLE, SEND, GAP};
  - NOC_ADDR_IDLE = 0;
  - a function computing the round-robin winner from (valid vector, rr pointer).
- One sub-module is natural: rr_arbiter. It is combinational: valid vector plus pointer in, one-hot grant plus index out.
- The FSM, counter and output registers stay in noc_tx_arbiter.

Test Plan:
1. Reset, then req0 valid with addr 0x12, data 0xDEADBEEF at t: ready[0] at t; addr_out=0x12/data_out=0xDEADBEEF for t+1..t+4; addr_out=0 at t+5..t+6; busy low at t+7.
2. All four requesters valid continuously with distinct addrs 0x10..0x13: grant order 0,1,2,3,0,...; each ready exactly once per 7-cycle period.
3. req2 only valid, then req1 and req3 both valid while req2 is in SEND: next grant is req3 (rr after 2), then req1.
4. req1 valid with addr 0x00: ready[1] pulses, drop_err=1 next cycle, addr_out stays 0, busy stays 0; next accept possible the cycle after.
5. Reset asserted at the 2nd SEND cycle: next cycle addr_out=0, data_out=0, busy=0, grant_id=3; pending req0 is then accepted first.
6. req3 asserts valid for one cycle during GAP, then drops it: never granted, no transfer, no ready pulse.
